// File: rtl/pipeline_chain.sv
// pipeline_chain: parametrised in-order pipeline backbone with stall, bubble, flush and perf counters.
//   clk, rst (async active-low)      : clock and reset
//   in_valid/in_data/in_ready        : stage 0 entry handshake
//   stall_req/flush_req [STAGES]     : per-stage hold and kill requests
//   cnt_clear                        : synchronous clear of both counters
//   stage_valid/stage_data           : registered per-stage state, stage i at [i*DATA_W +: DATA_W]
//   out_valid/out_data               : retirement from the oldest stage
//   retire_count/bubble_count        : saturating performance counters
module pipeline_chain #(
  parameter int DATA_W = 32,
  parameter int STAGES = 5,
  parameter int CNT_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     in_ready,
  input  logic [STAGES-1:0]        stall_req,
  input  logic [STAGES-1:0]        flush_req,
  input  logic                     cnt_clear,
  output logic [STAGES-1:0]        stage_valid,
  output logic [STAGES*DATA_W-1:0] stage_data,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [CNT_W-1:0]         retire_count,
  output logic [CNT_W-1:0]         bubble_count
);
  localparam int L = STAGES - 1;
  logic [STAGES-1:0] w_hold, w_valid_nxt, r_valid;
  logic [DATA_W-1:0] r_data [STAGES];
  logic [CNT_W-1:0]  r_retire, r_bubble;
  logic              w_last_bubble;
  // A stall at stage j freezes j and everything younger, so hold[i] looks at all older requests.
  always_comb begin
    w_hold = '0;
    for (int i = 0; i < STAGES; i++) w_hold[i] = |(stall_req >> i);
  end
  // Flush dominates hold; the stage just below a stall boundary receives a bubble.
  always_comb begin
    w_valid_nxt = '0;
    w_valid_nxt[0] = w_hold[0] ? r_valid[0] & ~flush_req[0] : in_valid;
    for (int i = 1; i < STAGES; i++)
      w_valid_nxt[i] = w_hold[i]   ? r_valid[i] & ~flush_req[i]
                     : w_hold[i-1] ? 1'b0
                     : r_valid[i-1] & ~flush_req[i-1];
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_valid <= '0;
      for (int i = 0; i < STAGES; i++) r_data[i] <= '0;
    end else begin
      r_valid <= w_valid_nxt;
      if (!w_hold[0]) r_data[0] <= in_data;
      for (int i = 1; i < STAGES; i++) if (!w_hold[i]) r_data[i] <= r_data[i-1];
    end
  assign in_ready      = ~w_hold[0];
  assign out_valid     = r_valid[L] & ~flush_req[L] & ~w_hold[L];
  assign out_data      = r_data[L];
  assign w_last_bubble = ~w_hold[L] & ~(r_valid[L] & ~flush_req[L]);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_retire <= '0;
      r_bubble <= '0;
    end else begin
      r_retire <= cnt_clear ? '0 : (out_valid & ~&r_retire) ? r_retire + CNT_W'(1) : r_retire;
      r_bubble <= cnt_clear ? '0 : (w_last_bubble & ~&r_bubble) ? r_bubble + CNT_W'(1) : r_bubble;
    end
  assign retire_count = r_retire;
  assign bubble_count = r_bubble;
  assign stage_valid  = r_valid;
  for (genvar g = 0; g < STAGES; g++) begin : g_pack
    assign stage_data[g*DATA_W +: DATA_W] = r_data[g];
  end
endmodule

// File: tb/tb_pipeline_chain.sv
// tb_pipeline_chain: directed self-checking bench for pipeline_chain (main instance plus a 4-bit-counter twin).
module tb_pipeline_chain;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic [4:0]  stall_req, flush_req;
  logic        cnt_clear;
  logic        in_ready, out_valid;
  logic [4:0]  stage_valid;
  logic [39:0] stage_data;
  logic [7:0]  out_data;
  logic [31:0] retire_count, bubble_count;
  logic        s_in_ready, s_out_valid;
  logic [4:0]  s_stage_valid;
  logic [39:0] s_stage_data;
  logic [7:0]  s_out_data;
  logic [3:0]  s_retire_count, s_bubble_count;
  int          n_assert = 0;
  int          n_fail = 0;
  pipeline_chain #(.DATA_W(8), .STAGES(5), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .stall_req(stall_req), .flush_req(flush_req), .cnt_clear(cnt_clear),
    .stage_valid(stage_valid), .stage_data(stage_data), .out_valid(out_valid),
    .out_data(out_data), .retire_count(retire_count), .bubble_count(bubble_count));
  pipeline_chain #(.DATA_W(8), .STAGES(5), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(s_in_ready),
    .stall_req(stall_req), .flush_req(flush_req), .cnt_clear(cnt_clear),
    .stage_valid(s_stage_valid), .stage_data(s_stage_data), .out_valid(s_out_valid),
    .out_data(s_out_data), .retire_count(s_retire_count), .bubble_count(s_bubble_count));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = '0; stall_req = '0; flush_req = '0; cnt_clear = 1'b0;
    #2;
    chk("rst_valid", stage_valid, 5'b0);
    chk("rst_data", stage_data, 40'h0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_retire", retire_count, 0);
    chk("rst_bubble", bubble_count, 0);
    chk("rst_in_ready", in_ready, 1'b1);
    stall_req = 5'b00001;
    #1 chk("rst_in_ready_stalled", in_ready, 1'b0);
    stall_req = '0;
    tick;
    rst = 1'b1;
    // Streaming: 20 items, counters cleared at edge 5 so only the steady-state window is counted.
    for (int j = 1; j <= 25; j++) begin
      in_valid  = (j <= 20);
      in_data   = 8'(8'h10 + j - 1);
      cnt_clear = (j == 5 || j == 25);
      tick;
      chk("stream_in_ready", in_ready, 1'b1);
      chk("stream_out_valid", out_valid, (j >= 5 && j <= 24));
      if (j >= 5 && j <= 24) chk("stream_out_data", out_data, 8'h10 + j - 5);
      if (j == 1) chk("stream_first_valid", stage_valid, 5'b00001);
      if (j == 5) chk("stream_first_out", out_data, 8'h10);
      if (j == 24) begin
        chk("stream_retire", retire_count, 19);
        chk("stream_bubble", bubble_count, 0);
        chk("sat_retire", s_retire_count, 4'hF);
      end
      if (j == 25) begin
        chk("clear_retire", retire_count, 0);
        chk("clear_bubble", bubble_count, 0);
        chk("sat_clear", s_retire_count, 4'h0);
      end
    end
    cnt_clear = 1'b0;
    // Load-use stall on stage 1 holding 0xA.
    in_valid = 1'b1; in_data = 8'h0A;
    tick;
    in_valid = 1'b0;
    tick;
    stall_req = 5'b00010; in_valid = 1'b1; in_data = 8'h77;
    #1;
    chk("lu_in_ready", in_ready, 1'b0);
    chk("lu_valid_before", stage_valid, 5'b00010);
    tick;
    chk("lu_valid_held", stage_valid, 5'b00010);
    chk("lu_data_held", stage_data[15:8], 8'h0A);
    stall_req = '0; in_valid = 1'b0;
    tick;
    chk("lu_bubble_gone", stage_valid, 5'b00100);
    tick;
    chk("lu_not_yet", out_valid, 1'b0);
    tick;
    chk("lu_out_valid", out_valid, 1'b1);
    chk("lu_out_data", out_data, 8'h0A);
    chk("lu_bubble_count", bubble_count, 6);
    tick;
    chk("lu_retire", retire_count, 1);
    chk("lu_bubble_after", bubble_count, 6);
    // Branch flush of 0xB (stage 0) and 0xC (stage 1).
    in_valid = 1'b1; in_data = 8'h0C;
    tick;
    in_data = 8'h0B;
    tick;
    in_valid = 1'b0; flush_req = 5'b00011;
    #1;
    chk("fl_valid_before", stage_valid, 5'b00011);
    chk("fl_out_valid", out_valid, 1'b0);
    tick;
    flush_req = '0;
    chk("fl_valid_after", stage_valid, 5'b00000);
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("fl_no_retire", out_valid, 1'b0);
    end
    chk("fl_retire", retire_count, 1);
    // Flush while stalled on stage 4 holding 0xD.
    in_valid = 1'b1;
    in_data = 8'h0D; tick;
    in_data = 8'h21; tick;
    in_data = 8'h22; tick;
    in_data = 8'h23; tick;
    in_data = 8'h24; tick;
    chk("fs_full", stage_valid, 5'b11111);
    stall_req = 5'b10000; flush_req = 5'b10000; in_data = 8'h99;
    #1;
    chk("fs_out_valid", out_valid, 1'b0);
    chk("fs_in_ready", in_ready, 1'b0);
    tick;
    chk("fs_valid", stage_valid, 5'b01111);
    chk("fs_data", stage_data, {8'h0D, 8'h21, 8'h22, 8'h23, 8'h24});
    stall_req = '0; flush_req = '0; in_data = 8'h40;
    tick;
    chk("fs_next_out", out_valid, 1'b1);
    chk("fs_next_data", out_data, 8'h21);
    // Async reset mid-stream with every stage valid.
    for (int k = 1; k <= 4; k++) begin
      in_data = 8'(8'h40 + k);
      tick;
    end
    chk("ar_full", stage_valid, 5'b11111);
    #2 rst = 1'b0;
    #1;
    chk("ar_valid", stage_valid, 5'b0);
    chk("ar_data", stage_data, 40'h0);
    chk("ar_out_valid", out_valid, 1'b0);
    chk("ar_retire", retire_count, 0);
    #1 rst = 1'b1;
    in_data = 8'h5A;
    tick;
    in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      chk("ar_wait", out_valid, 1'b0);
      tick;
    end
    chk("ar_out_valid_late", out_valid, 1'b1);
    chk("ar_out_data", out_data, 8'h5A);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/pipeline_chain.md
# pipeline_chain

Parametrised N-stage in-order pipeline backbone: payload registers, per-stage valid bits, stall propagation, bubble insertion and selective flush, plus retire and bubble performance counters. Generalises the fixed IF/ID, ID/EX, EX/MEM and MEM/WB register set with hard-wired stall and flush into one block of configurable depth and width. The core instantiates it between fetch and writeback. Hazard and branch logic drive `stall_req` and `flush_req`.

## Interface
Parameters:
- `DATA_W`, 32: payload width per stage.
- `STAGES`, 5: number of stages, minimum 2. Stage 0 is youngest; stage `STAGES-1` is oldest.
- `CNT_W`, 32: width of each performance counter.

Ports:
- `clk` input, 1: the single clock; all state changes on the rising edge.
- `rst` input, 1: asynchronous, active-low reset.
- `in_valid` input, 1: a new item is presented at stage 0.
- `in_data` input, `DATA_W`: payload of the new item.
- `in_ready` output, 1: stage 0 accepts this cycle.
- `stall_req` input, `STAGES`: bit i asks stage i to hold.
- `flush_req` input, `STAGES`: bit i kills the item currently in stage i.
- `cnt_clear` input, 1: synchronous clear of both counters.
- `stage_valid` output, `STAGES`: registered valid bit of each stage.
- `stage_data` output, `STAGES*DATA_W`: registered payloads; stage i occupies bits `[i*DATA_W +: DATA_W]`.
- `out_valid` output, 1: the oldest stage retires this cycle.
- `out_data` output, `DATA_W`: payload of stage `STAGES-1`.
- `retire_count` output, `CNT_W`: number of items retired.
- `bubble_count` output, `CNT_W`: number of empty slots that left the last stage.

## Operation
- `hold[i]` is the OR of `stall_req[j]` for all j ≥ i. A stall freezes the requesting stage and every younger stage.
- `in_ready = ~hold[0]`. An item is accepted when `in_valid & in_ready`.
- Next valid of stage i, evaluated in this priority order:
  - If `hold[i]`: `valid[i] & ~flush_req[i]`. The stage holds; a flush while held kills the content in place.
  - Else if i == 0: `in_valid`.
  - Else if `hold[i-1]` (stall boundary sits at stage i-1): 0. A bubble is inserted.
  - Else: `valid[i-1] & ~flush_req[i-1]`. The item advances; a flushed item arrives as a bubble.
- Data register i loads on every edge where `hold[i]` is 0: from `in_data` for stage 0, otherwise from `data[i-1]`. Payload of an invalid stage is don't-care but is never X after reset.
- `out_valid = valid[STAGES-1] & ~flush_req[STAGES-1] & ~hold[STAGES-1]`. `out_data = data[STAGES-1]`.
- `retire_count` increments on each cycle `out_valid` is 1.
- `bubble_count` increments on each cycle where `~hold[STAGES-1]` and the last stage holds an invalid or flushed item.
- Both counters saturate at all-ones.
- `cnt_clear` forces both counters to 0 and takes priority over increments in the same cycle.
- Flush always dominates hold for the valid bit. Simultaneous stall and flush on one stage: the stage holds with valid 0.

## Timing
- Reset (`rst` = 0, asynchronous): all `stage_valid` = 0, all `stage_data` = 0, both counters = 0, so `out_valid` = 0. `in_ready` follows `stall_req` combinationally even during reset.
- Latency: an item accepted at edge n appears in stage k after edge n+k. It is presented on `out_valid` in the cycle after edge n+STAGES-1 when there are no stalls. Throughput is one item per cycle.
- Combinational paths: `stall_req` → `in_ready`/`out_valid`; `flush_req` → `out_valid`. No other input-to-output path exists.
- Each stall cycle at stage k inserts exactly one bubble into stage k+1.
- Releasing a stall causes no duplicated items and no lost items.
- Reset asserted mid-operation discards all in-flight items immediately.

## Test plan
- Streaming: STAGES=5, feed 0x10..0x19 on consecutive cycles with no stalls → first `out_valid` carries 0x10 in the cycle after the 5th edge; ten consecutive retires; `retire_count` = 10, `bubble_count` = 0 once idle resumes.
- Load-use stall: `stall_req[1]` held for 1 cycle with 0xA in stage 1 → stages 0–1 frozen, `in_ready` = 0 that cycle, stage 2 gets a bubble; 0xA retires one cycle late; `bubble_count` +1.
- Branch flush: `flush_req` = 5'b00011 with 0xB in stage 0 and 0xC in stage 1 → neither retires; two bubbles reach stage 4; `retire_count` is unchanged by them.
- Flush while stalled: `stall_req[4]` = 1 and `flush_req[4]` = 1 with 0xD in stage 4 → `out_valid` = 0; stage 4 valid = 0 next cycle; stages 0–3 unchanged.
- Counter saturation and clear: CNT_W=4, retire 20 items → `retire_count` = 15; `cnt_clear` pulsed together with a retire → 0.
- Async reset mid-stream: `rst` = 0 between edges with all stages valid → `stage_valid` = 0 immediately; first accepted item after release retires STAGES cycles later.
